// File: rtl/phase_dump_ctrl_if.sv
// Phase-word stream in and dump-BRAM write port out.
// slave: the dump controller; master: the datapath/BRAM side.
interface phase_dump_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
);
  logic              in_valid;
  logic              in_sync;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;

  modport slave (
    input  in_valid,
    input  in_sync,
    input  in_data,
    output bram_addr,
    output bram_din,
    output bram_we
  );

  modport master (
    output in_valid,
    output in_sync,
    output in_data,
    input  bram_addr,
    input  bram_din,
    input  bram_we
  );
endinterface

// File: rtl/phase_dump_ctrl.sv
// Phase-snapshot dump sequencer: arms on enable edge, aligns to
// frame sync, writes len+1 words single-shot or wrapping.
module phase_dump_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int WRAP_W = 16
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       dmp_cfg,
  phase_dump_ctrl_if.slave  bus,
  output logic              stat_busy,
  output logic              stat_done,
  output logic [WRAP_W-1:0] stat_wraps
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic              en_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              cont_q, cont_d;
  logic              done_q, done_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;

  logic en;
  logic en_rise;
  logic at_len;
  logic last_wr;
  logic unused_cfg;

  assign en      = dmp_cfg[0];
  assign en_rise = en & ~en_q;
  assign at_len  = (addr_q == len_q);
  assign last_wr = we_q & at_len;
  assign unused_cfg = ^{dmp_cfg[31:ADDR_W+16],
                        dmp_cfg[15:2]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    din_d   = din_q;
    we_d    = 1'b0;
    cont_d  = cont_q;
    done_d  = done_q;
    wraps_d = wraps_q;
    unique case (state_q)
      IDLE: begin
        if (en_rise) begin
          state_d = ARMED;
          len_d   = dmp_cfg[ADDR_W+15:16];
          cont_d  = dmp_cfg[1];
          done_d  = 1'b0;
          wraps_d = '0;
        end
      end
      ARMED: begin
        if (!en) begin
          state_d = IDLE;
        end else if (bus.in_valid && bus.in_sync) begin
          state_d = CAPTURE;
          we_d    = 1'b1;
          addr_d  = '0;
          din_d   = bus.in_data;
        end
      end
      CAPTURE: begin
        if (!en) begin
          state_d = IDLE;
        end else if (last_wr && !cont_q) begin
          // Word arriving alongside the final write is dropped.
          state_d = DONE;
          done_d  = 1'b1;
        end else if (bus.in_valid) begin
          we_d  = 1'b1;
          din_d = bus.in_data;
          if (at_len) begin
            addr_d = '0;
            if (wraps_q != '1)
              wraps_d = wraps_q + WRAP_W'(1);
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        if (!en)
          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      cont_q  <= 1'b0;
      done_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en;
      addr_q  <= addr_d;
      len_q   <= len_d;
      din_q   <= din_d;
      we_q    <= we_d;
      cont_q  <= cont_d;
      done_q  <= done_d;
      wraps_q <= wraps_d;
    end
  end

  assign bus.bram_addr = addr_q;
  assign bus.bram_din  = din_q;
  assign bus.bram_we   = we_q;
  assign stat_busy  = (state_q == ARMED) ||
                      (state_q == CAPTURE);
  assign stat_done  = done_q;
  assign stat_wraps = wraps_q;

endmodule
